// File: rtl/pwm_pkg.sv
// PWM shared definitions: decoder FSM states, brightness level codes,
// and duty threshold multipliers (thresholds at k/8 of the period).
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_e;

  localparam logic [2:0] LVL_5   = 3'd0;
  localparam logic [2:0] LVL_25  = 3'd1;
  localparam logic [2:0] LVL_50  = 3'd2;
  localparam logic [2:0] LVL_75  = 3'd3;
  localparam logic [2:0] LVL_100 = 3'd4;

  localparam int K1 = 1;
  localparam int K3 = 3;
  localparam int K5 = 5;
  localparam int K7 = 7;

endpackage

// File: rtl/pwm_duty_decoder_sync_edge.sv
// Two-flop synchronizer plus edge detector for an asynchronous line.
// Reusable for buttons and other slow external inputs.
module pwm_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  // synchronizer chain and previous-value flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  assign rise_o = s2_q & ~prev_q;
  assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures period and high time of an external PWM line and
// quantizes its duty into brightness level 0..4.
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int          CNT_W   = 21,
  parameter int unsigned TIMEOUT = 2000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pwm_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [2:0]       level,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic sync;
  logic rise;
  logic fall;

  pwm_sync_edge u_sync (
    .clk    (clk),
    .rst_n  (reset_n),
    .d_i    (pwm_in),
    .sync_o (sync),
    .rise_o (rise),
    .fall_o (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcap_q, hcap_d;
  logic             held_q, held_d;
  logic             mv_q, mv_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [2:0]       lvl_q, lvl_d;
  logic             stk_q, stk_d;

  logic             timeout;
  logic             rep_stk;
  logic             rep_norm;
  logic             line_hi;
  logic [CNT_W+2:0] h8;
  logic [CNT_W+2:0] pext;
  logic [3:0]       ge;
  logic [2:0]       quant;

  function automatic logic [CNT_W+2:0] kmul(
    input logic [CNT_W+2:0] p,
    input int               k
  );
    logic [CNT_W+2:0] r;
    r = p;
    unique case (k)
      K1:      r = p;
      K3:      r = (p << 1) + p;
      K5:      r = (p << 2) + p;
      K7:      r = (p << 3) - p;
      default: r = p;
    endcase
    return r;
  endfunction

  // duty thresholds: 8*high against k*period, candidate period = cnt
  always_comb begin
    h8    = {hcap_q, 3'b000};
    pext  = {3'b000, cnt_q};
    ge[0] = h8 >= kmul(pext, K1);
    ge[1] = h8 >= kmul(pext, K3);
    ge[2] = h8 >= kmul(pext, K5);
    ge[3] = h8 >= kmul(pext, K7);
    quant = {2'b00, ge[0]} + {2'b00, ge[1]}
          + {2'b00, ge[2]} + {2'b00, ge[3]};
  end

  // measurement FSM and report formation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcap_d   = hcap_q;
    held_d   = held_q;
    mv_d     = 1'b0;
    per_d    = per_q;
    hi_d     = hi_q;
    lvl_d    = lvl_q;
    stk_d    = stk_q;
    rep_stk  = 1'b0;
    rep_norm = 1'b0;
    line_hi  = 1'b0;
    timeout  = (cnt_q == TO);
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d   = ONE;
          held_d  = 1'b0;
          state_d = HIGH;
        end else if (timeout) begin
          if (!held_q) begin
            rep_stk = 1'b1;
            line_hi = sync;
            held_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      HIGH: begin
        if (timeout) begin
          rep_stk = 1'b1;
          line_hi = 1'b1;
          held_d  = 1'b1;
          state_d = IDLE;
        end else if (fall) begin
          hcap_d  = cnt_q;
          cnt_d   = cnt_q + ONE;
          state_d = LOW;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      LOW: begin
        if (rise) begin
          rep_norm = 1'b1;
          cnt_d    = ONE;
          state_d  = HIGH;
        end else if (timeout) begin
          rep_stk = 1'b1;
          held_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rep_stk) begin
      mv_d  = 1'b1;
      per_d = TO;
      hi_d  = line_hi ? TO : '0;
      lvl_d = line_hi ? LVL_100 : LVL_5;
      stk_d = 1'b1;
    end else if (rep_norm) begin
      mv_d  = 1'b1;
      per_d = cnt_q;
      hi_d  = hcap_q;
      lvl_d = quant;
      stk_d = 1'b0;
    end
  end

  // state, counters and held report registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hcap_q  <= '0;
      held_q  <= 1'b0;
      mv_q    <= 1'b0;
      per_q   <= '0;
      hi_q    <= '0;
      lvl_q   <= LVL_5;
      stk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcap_q  <= hcap_d;
      held_q  <= held_d;
      mv_q    <= mv_d;
      per_q   <= per_d;
      hi_q    <= hi_d;
      lvl_q   <= lvl_d;
      stk_q   <= stk_d;
    end
  end

  assign meas_valid = mv_q;
  assign period     = per_q;
  assign high_time  = hi_q;
  assign level      = lvl_q;
  assign stuck      = stk_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder: directed and random PWM
// waveforms compared against a duty-ratio reference model.
module tb_pwm_duty_decoder;

  localparam int CW = 21;
  localparam int TO = 4096;

  logic          clk;
  logic          reset_n;
  logic          pwm_in;
  logic          meas_valid;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic [2:0]    level;
  logic          stuck;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int dbl      = 0;
  logic prev_mv = 1'b0;

  typedef struct {
    int per;
    int hi;
    int lvl;
    int stk;
    int cyc;
  } rep_t;

  rep_t q[$];

  pwm_duty_decoder #(
    .CNT_W   (CW),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pwm_in     (pwm_in),
    .meas_valid (meas_valid),
    .period     (period),
    .high_time  (high_time),
    .level      (level),
    .stuck      (stuck)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      rep_t r;
      r.per = int'(period);
      r.hi  = int'(high_time);
      r.lvl = int'(level);
      r.stk = int'(stuck);
      r.cyc = cyc;
      q.push_back(r);
      if (prev_mv === 1'b1) dbl++;
    end
    prev_mv = meas_valid;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_level(input int p, input int h);
    real d;
    int  n;
    d = real'(h) / real'(p);
    n = 0;
    if (d >= 0.125) n++;
    if (d >= 0.375) n++;
    if (d >= 0.625) n++;
    if (d >= 0.875) n++;
    return n;
  endfunction

  task automatic outs_zero(input string tag);
    check({tag, "_mv"}, int'(meas_valid), 0);
    check({tag, "_per"}, int'(period), 0);
    check({tag, "_hi"}, int'(high_time), 0);
    check({tag, "_lvl"}, int'(level), 0);
    check({tag, "_stk"}, int'(stuck), 0);
  endtask

  task automatic do_reset(input string tag);
    pwm_in  = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    outs_zero(tag);
    reset_n = 1'b1;
    @(negedge clk);
    q.delete();
  endtask

  task automatic pwm_run(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      repeat (h) @(negedge clk);
      pwm_in = 1'b0;
      repeat (p - h) @(negedge clk);
    end
  endtask

  task automatic expect_reports(
    input string tag, input int p, input int h, input int n
  );
    repeat (8) @(negedge clk);
    check({tag, "_count"}, q.size(), n);
    foreach (q[i]) begin
      check({tag, "_per"}, q[i].per, p);
      check({tag, "_hi"}, q[i].hi, h);
      check({tag, "_lvl"}, q[i].lvl, ref_level(p, h));
      check({tag, "_stk"}, q[i].stk, 0);
    end
    q.delete();
  endtask

  int c0;
  int sweep_h[4] = '{250, 500, 750, 999};
  int thr_h[5]   = '{99, 100, 299, 300, 700};

  initial begin
    pwm_in  = 1'b0;
    reset_n = 1'b0;

    // static low line from reset: one stuck report only
    do_reset("rst0");
    repeat (4000) @(negedge clk);
    check("idle_early", q.size(), 0);
    repeat (300) @(negedge clk);
    check("idle_count", q.size(), 1);
    if (q.size() > 0) begin
      check("idle_per", q[0].per, TO);
      check("idle_hi", q[0].hi, 0);
      check("idle_lvl", q[0].lvl, 0);
      check("idle_stk", q[0].stk, 1);
    end
    repeat (4300) @(negedge clk);
    check("idle_frozen", q.size(), 1);

    // 1000/50 steady PWM, first-report latency and spacing
    do_reset("rst1");
    pwm_run(1000, 50, 1);
    c0 = cyc;
    pwm_run(1000, 50, 3);
    repeat (8) @(negedge clk);
    check("p5_nrep", q.size(), 3);
    if (q.size() >= 2) begin
      check("p5_latency", q[0].cyc - c0, 3);
      check("p5_spacing", q[1].cyc - q[0].cyc, 1000);
    end
    expect_reports("p5", 1000, 50, 3);

    // level sweep at period 1000
    foreach (sweep_h[i]) begin
      do_reset("rst_sw");
      pwm_run(1000, sweep_h[i], 2);
      expect_reports("sweep", 1000, sweep_h[i], 1);
    end

    // threshold edges at period 800
    foreach (thr_h[i]) begin
      do_reset("rst_th");
      pwm_run(800, thr_h[i], 2);
      expect_reports("thr", 800, thr_h[i], 1);
    end
    check("thr_model_99", ref_level(800, 99), 0);
    check("thr_model_700", ref_level(800, 700), 4);

    // line stuck high, then PWM resumes
    do_reset("rst_sh");
    pwm_in = 1'b1;
    repeat (4300) @(negedge clk);
    check("sh_count", q.size(), 1);
    if (q.size() > 0) begin
      check("sh_per", q[0].per, TO);
      check("sh_hi", q[0].hi, TO);
      check("sh_lvl", q[0].lvl, 4);
      check("sh_stk", q[0].stk, 1);
    end
    q.delete();
    pwm_in = 1'b0;
    repeat (20) @(negedge clk);
    check("sh_quiet", q.size(), 0);
    pwm_run(1000, 500, 1);
    check("sh_one_rise", q.size(), 0);
    pwm_run(1000, 500, 2);
    expect_reports("sh_resume", 1000, 500, 2);

    // asynchronous reset in the middle of a high phase
    pwm_in = 1'b1;
    repeat (100) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    outs_zero("arst");
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    q.delete();
    pwm_run(1000, 500, 1);
    check("arst_one_rise", q.size(), 0);
    pwm_run(1000, 500, 2);
    expect_reports("arst_resume", 1000, 500, 2);

    // random period/high pairs
    for (int i = 0; i < 6; i++) begin
      int p;
      int h;
      p = int'($urandom_range(900, 16));
      h = int'($urandom_range(p - 1, 1));
      do_reset("rst_rnd");
      pwm_run(p, h, 3);
      expect_reports("rnd", p, h, 2);
    end

    check("no_back_to_back", dbl, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
- Receive-side counterpart of the LED brightness PWM generator.
- Samples an external PWM line, measures its period and high time in clk cycles, and quantizes duty to brightness level 0..4.
- Level mapping matches the generator's five steps: 5/25/50/75/100 %.
- Used to loop back or verify PWM outputs and to accept brightness commands from another board.

Parameters:
- CNT_W, 21, width of period/high-time counters and outputs.
- TIMEOUT, 2000000, cycles without a closing edge before a stuck-line report; must be < 2^CNT_W.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset_n  input  1  asynchronous active-low reset.
- pwm_in  input  1  asynchronous PWM line.
- meas_valid  output  1  one-cycle pulse; all result outputs updated this cycle.
- period  output  CNT_W  last measured period, clk cycles.
- high_time  output  CNT_W  last measured high time, clk cycles.
- level  output  3  quantized duty, 0..4.
- stuck  output  1  1 = last report was a timeout (line static).

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0; FSM to IDLE; counters 0.
- Input conditioning:
  - pwm_in passes through a 2-flop synchronizer plus a previous-value flop.
  - rise/fall are single-cycle strobes on the synchronized signal.
  - All counts refer to the synchronized signal, so synchronizer latency does not bias measurements.
- FSM states:
  - IDLE: waiting for first rise.
    - cnt increments each cycle.
    - On rise: cnt<=1, go HIGH.
    - If cnt reaches TIMEOUT: issue stuck report once, then cnt freezes until a rise.
  - HIGH: cnt increments.
    - On fall: hcap<=cnt, go LOW.
    - On cnt==TIMEOUT: stuck report, go IDLE.
  - LOW: cnt increments.
    - On rise: pcap<=cnt, cnt<=1, go HIGH, raise compute strobe.
    - On cnt==TIMEOUT: stuck report, go IDLE.
- Normal report:
  - Counts: period = cycles rise-to-rise; high_time = cycles rise-to-fall.
  - Timing: compute strobe on cycle E (rise detected); outputs updated and meas_valid=1 on cycle E+1.
  - Flags: stuck<=0.
  - Steady-state PWM: one report per period; the first report needs two rises after reset or IDLE.
- Level quantization, registered in the E+1 update:
  - Compare 8*high_time against k*period, k in {1,3,5,7}.
  - Use CNT_W+3-bit arithmetic, shift-add only, no multipliers.
  - level = number of k satisfying 8*high_time >= k*period.
  - Result: 5 %→0, 25 %→1, 50 %→2, 75 %→3, 100 %→4.
- Stuck report:
  - Fields: period<=TIMEOUT; stuck<=1; meas_valid pulses.
  - Line high: high_time<=TIMEOUT, level<=4.
  - Line low: high_time<=0, level<=0.
- Outputs hold between reports; meas_valid is never high two consecutive cycles.
- Boundary rules:
  - Counters never wrap: TIMEOUT < 2^CNT_W, and TIMEOUT forces exit.
  - Minimum high or low phase is 1 cycle; pulses shorter than the synchronizer can resolve may be lost. This is accepted, not flagged.
  - Reset mid-measurement discards partial counts.

Decomposition:
- Shared package pwm_pkg:
  - state enum {IDLE, HIGH, LOW};
  - level constants LVL_5, LVL_25, LVL_50, LVL_75, LVL_100 (0..4);
  - threshold multiplier constants 1/3/5/7.
- The generator side imports the same level constants.
- One sub-module: pwm_sync_edge.
  - 2-flop synchronizer plus edge detector.
  - Outputs sync, rise, fall.
  - Async active-low reset to 0.
  - Reusable for button inputs.

Test Plan:
- Reset, pwm_in=0, no edges, TIMEOUT=4096 → all outputs 0 until cycle 4096; then one meas_valid pulse with stuck=1, level=0, period=4096, high_time=0; no further pulses.
- PWM period 1000 / high 50, 4 periods → first meas_valid one cycle after second synchronized rise; every report has period=1000, high_time=50, level=0, stuck=0, one pulse per period.
- Sweep high 250/500/750/1000-1 with period 1000 → level 1/2/3/4 respectively; period=1000 each time.
- Thresholds, period 800 → high 99→0, 100→1, 299→1, 300→2, 700→4.
- TIMEOUT=4096, one rise then held high → report at count 4096: stuck=1, level=4, high_time=4096. Resume PWM 1000/500 → the first report needs two new rises and shows stuck=0, level=2.
- reset_n low mid-HIGH, asynchronously between clk edges → outputs 0 immediately. After release, 1000/500 PWM → no report until second rise, then correct values.
